// File: rtl/insmem_sync.sv
// ---------------------------------------------------------------------------
// insmem_sync -- synchronous instruction memory with a one-entry fetch
// output register and an optional per-word parity check.
//
// Program words are loaded through the write port (wr_en/wr_addr/wr_data).
// Fetches are requested with rd_req. The fetch address is either rd_addr or,
// with seq_mode=1, an internal program counter (PC). An accepted fetch shows
// up on rd_data / rd_addr_q with rd_valid=1 one cycle later. The output stays
// held until the consumer takes it with rd_ready.
//
// Handshake: rd_gnt = rd_req & (~rd_valid | rd_ready), forced to 0 in reset.
//   A request is accepted exactly on a cycle where rd_gnt=1. rd_valid/rd_data
//   change only on an accepted request (load) or on rd_ready with no request
//   accepted (drain). While rd_valid=1 and rd_ready=0 the outputs hold.
//
// Optional feature: define INSMEM_PARITY_EN to store one even-parity bit per
//   word. par_inj=1 inverts the stored bit on a write. A fetched word whose
//   stored bit does not match its data raises rd_perr with rd_valid. Without
//   the macro, there is no parity storage, rd_perr is 0 and par_inj is unused.
//
// Parameters:
//   DATA_W    instruction word width
//   ADDR_W    word-address width (depth = 2**ADDR_W)
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      synchronous active-low reset (memory contents are kept)
//   wr_en      program-load write strobe
//   wr_addr    program-load word address
//   wr_data    program-load word
//   par_inj    invert the stored parity bit of this write
//   seq_mode   1: fetch from PC, 0: fetch from rd_addr
//   pc_ld      load PC from pc_val (wins over the increment)
//   pc_val     PC load value
//   rd_req     fetch request
//   rd_addr    fetch address used when seq_mode=0
//   rd_gnt     request accepted this cycle (combinational)
//   rd_valid   rd_data holds a fetched word
//   rd_ready   consumer takes rd_data this cycle
//   rd_data    fetched word
//   rd_addr_q  address of the word in rd_data
//   rd_perr    parity error on the word in rd_data, qualified by rd_valid
// ---------------------------------------------------------------------------
module insmem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              seq_mode,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_val,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr_q,
  input  logic              par_inj,
  output logic              rd_perr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_word;
  logic              fetch_perr;
  logic              wr_hit;
  logic              seq_take;
  logic              perr_q;

  // Accept when the output register is empty or being drained this cycle.
  assign rd_gnt = rst_n & rd_req & (~rd_valid | rd_ready);

  // A same-cycle pc_ld redirects the sequential fetch to pc_val.
  always_comb begin
    fetch_addr = rd_addr;
    if (seq_mode) begin
      fetch_addr = pc_ld ? pc_val : pc;
    end
  end

  // Write-first: a same-cycle write to the fetch address is forwarded.
  assign wr_hit     = wr_en & (wr_addr == fetch_addr);
  assign fetch_word = wr_hit ? wr_data : mem[fetch_addr];

  // Memory array has no reset; program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef INSMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;

  // Even parity over the data word, optionally inverted for error injection.
  assign wr_par = (^wr_data) ^ par_inj;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wr_addr] <= wr_par;
    end
  end

  assign fetch_perr = (wr_hit ? wr_par : par_mem[fetch_addr]) ^ (^fetch_word);
`else
  logic unused_par_inj;

  assign unused_par_inj = par_inj;
  assign fetch_perr     = 1'b0;
`endif

  // PC next-state: load wins; a load coinciding with a sequential fetch
  // consumes pc_val and leaves the PC pointing past it.
  assign seq_take = rd_gnt & seq_mode;

  always_comb begin
    pc_nxt = pc;
    if (pc_ld) begin
      pc_nxt = seq_take ? pc_val + 1'b1 : pc_val;
    end else if (seq_take) begin
      pc_nxt = pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_nxt;
    end
  end

  // Output register: load on grant, drain on rd_ready, otherwise hold.
  // Data/address are left as-is on a drain; only rd_valid qualifies them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr_q <= '0;
      perr_q    <= 1'b0;
    end else if (rd_gnt) begin
      rd_valid  <= 1'b1;
      rd_data   <= fetch_word;
      rd_addr_q <= fetch_addr;
      perr_q    <= fetch_perr;
    end else if (rd_ready) begin
      rd_valid  <= 1'b0;
    end
  end

  assign rd_perr = rd_valid & perr_q;

endmodule

// File: doc/insmem_sync.md
INSMEM_SYNC -- requirements
Module: insmem_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning word-address width; depth is 2**ADDR_W words.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port wr_en  input  1  program-load write strobe.
REQ-006 The block SHALL have port wr_addr  input  ADDR_W  program-load word address.
REQ-007 The block SHALL have port wr_data  input  DATA_W  program-load word.
REQ-008 The block SHALL have port seq_mode  input  1  1 = fetch address comes from the internal PC, 0 = from rd_addr.
REQ-009 The block SHALL have port pc_ld  input  1  load the internal PC from pc_val.
REQ-010 The block SHALL have port pc_val  input  ADDR_W  PC load value.
REQ-011 The block SHALL have port rd_req  input  1  fetch request.
REQ-012 The block SHALL have port rd_addr  input  ADDR_W  fetch word address used when seq_mode=0.
REQ-013 The block SHALL have port rd_gnt  output  1  combinational; rd_req is accepted this cycle.
REQ-014 The block SHALL have port rd_valid  output  1  rd_data holds a fetched word.
REQ-015 The block SHALL have port rd_ready  input  1  consumer takes rd_data this cycle.
REQ-016 The block SHALL have port rd_data  output  DATA_W  fetched instruction word.
REQ-017 The block SHALL have port rd_addr_q  output  ADDR_W  address of the word in rd_data.
REQ-018 The block SHALL have port par_inj  input  1  invert the stored parity bit of the current write.
REQ-019 The block SHALL have port rd_perr  output  1  parity error flag qualified by rd_valid.

Function
REQ-020 The block SHALL assert rd_gnt = rd_req & (~rd_valid | rd_ready), and SHALL hold rd_gnt at 0 while rst_n=0.
REQ-021 On an accepted request, the block SHALL present the word at the fetch address on rd_data with rd_valid=1 on the next cycle; latency is 1 cycle.
REQ-022 The block SHALL allow back-to-back accepted requests, giving one word per cycle while rd_ready=1.
REQ-023 While rd_valid=1 and rd_ready=0, the block SHALL hold rd_data, rd_addr_q and rd_perr stable and SHALL deassert rd_gnt.
REQ-024 When rd_valid=1, rd_ready=1 and no request is accepted, the block SHALL clear rd_valid on the next cycle.
REQ-025 The block SHALL write wr_data to wr_addr on every cycle with wr_en=1, independently of the read handshake.
REQ-026 On a same-cycle write and accepted read to the same address, the block SHALL return the new wr_data (write-first).
REQ-027 A write to the address currently held in rd_data SHALL NOT alter the held rd_data.
REQ-028 In seq_mode=1, the fetch address SHALL be the PC, and the PC SHALL increment by 1 on each accepted request.
REQ-029 The PC SHALL wrap from 2**ADDR_W-1 to 0.
REQ-030 pc_ld=1 SHALL set the PC to pc_val, taking priority over the increment.
REQ-031 If pc_ld=1 coincides with an accepted seq_mode request, the block SHALL fetch from pc_val and set the PC to pc_val+1.
REQ-032 In seq_mode=0, the PC SHALL be unchanged except by pc_ld.

Reset
REQ-033 The block SHALL apply reset only on a clk edge where rst_n=0.
REQ-034 On reset, the block SHALL set rd_valid=0, rd_data=0, rd_addr_q=0, rd_perr=0 and PC=0.
REQ-035 Reset SHALL NOT clear memory contents.
REQ-036 A fetch in flight when reset is asserted SHALL be discarded, with no rd_valid pulse afterwards.

Configuration
REQ-037 With INSMEM_PARITY_EN defined, the block SHALL store one even-parity bit per word, inverted when par_inj=1.
REQ-038 With INSMEM_PARITY_EN defined, the block SHALL set rd_perr=1 with rd_valid=1 when the stored parity mismatches the fetched word.
REQ-039 Without INSMEM_PARITY_EN, the block SHALL have no parity storage, SHALL tie rd_perr to 0 and SHALL ignore par_inj.

Verification
REQ-040 The bench SHALL cover: DATA_W=32, ADDR_W=4; write 32'hFFFFFFFF at address 15, then rd_req with rd_addr=14 then 15 -> rd_data is word 14, then 32'hFFFFFFFF, each 1 cycle after grant.
REQ-041 The bench SHALL cover: rd_ready=0 for 3 cycles with rd_valid=1 -> rd_gnt=0 and rd_data stable; rd_ready=1 -> the next word is delivered on the following cycle.
REQ-042 The bench SHALL cover: seq_mode=1, pc_ld with pc_val=14, then 3 accepted requests -> rd_addr_q sequence 14, 15, 0.
REQ-043 The bench SHALL cover: same-cycle wr_en with addr 5, data 32'h12345678 and rd_req with addr 5 -> rd_data=32'h12345678.
REQ-044 The bench SHALL cover: with INSMEM_PARITY_EN, write addr 3 with par_inj=1, then read addr 3 -> rd_perr=1; rewrite with par_inj=0 and read -> rd_perr=0.
REQ-045 The bench SHALL cover: rst_n=0 for 1 cycle during a grant -> next cycle rd_valid=0, rd_data=0, PC=0, and previously written memory words read back unchanged.
